// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads one 16-word block, then streams (W[t], K[t], t) for P_ROUNDS rounds.
// Latency: first pair valid 1 cycle after the 16th input word; OUT_READY low holds every output and all state.
module sha256_msg_sched #(
    parameter int P_ROUNDS = 64
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        CLR,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_W,
    output logic [31:0] OUT_K,
    output logic [5:0]  OUT_T,
    output logic        OUT_LAST,
    output logic        BUSY
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [5:0] T_LAST = 6'(P_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];

    logic        in_hs;
    logic        out_hs;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] k_of(input logic [5:0] t);
        logic [31:0] k;
        k = 32'h0;
        case (t)
            6'd0:  k = 32'h428a2f98;
            6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;
            6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;
            6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;
            6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;
            6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;
            6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;
            6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;
            6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;
            6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;
            6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;
            6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;
            6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;
            6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;
            6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;
            6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;
            6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;
            6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;
            6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;
            6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;
            6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;
            6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;
            6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;
            6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;
            6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;
            6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;
            6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;
            6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;
            6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;
            6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;
            6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;
            6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;
            6'd63: k = 32'hc67178f2;
            default: k = 32'h0;
        endcase
        return k;
    endfunction

    // The same 16-deep window serves as load shift register and schedule recurrence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        w_d     = w_q;
        in_hs   = (state_q == ST_LOAD) && IN_VALID;
        out_hs  = (state_q == ST_RUN) && OUT_READY;
        w_new   = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

        if (CLR) begin
            state_d = ST_LOAD;
            cnt_d   = 4'd0;
            t_d     = 6'd0;
        end else if (in_hs) begin
            for (int k = 0; k < 15; k++) begin
                w_d[k] = w_q[k+1];
            end
            w_d[15] = IN_DATA;
            if (cnt_q == 4'd15) begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
                t_d     = 6'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (out_hs) begin
            for (int k = 0; k < 15; k++) begin
                w_d[k] = w_q[k+1];
            end
            w_d[15] = w_new;
            if (t_q == T_LAST) begin
                state_d = ST_LOAD;
                t_d     = 6'd0;
            end else begin
                t_d = t_q + 6'd1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= ST_LOAD;
            cnt_q   <= 4'd0;
            t_q     <= 6'd0;
            for (int k = 0; k < 16; k++) begin
                w_q[k] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            for (int k = 0; k < 16; k++) begin
                w_q[k] <= w_d[k];
            end
        end
    end

    assign IN_READY  = (state_q == ST_LOAD);
    assign OUT_VALID = (state_q == ST_RUN);
    assign BUSY      = (state_q == ST_RUN);
    assign OUT_W     = w_q[0];
    assign OUT_T     = t_q;
    assign OUT_K     = k_of(t_q);
    assign OUT_LAST  = (state_q == ST_RUN) && (t_q == T_LAST);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: FIPS-form schedule model with a per-cycle scoreboard,
// plus literal pins on known "abc" words and the full SHA-256 digest of the emitted pairs.
`timescale 1ns/1ps
module tb_sha256_msg_sched;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, out_last, busy;
    logic [31:0] out_w, out_k;
    logic [5:0]  out_t;

    logic        r_in_valid = 1'b0;
    logic [31:0] r_in_data = 32'h0;
    logic        r_out_ready = 1'b1;
    logic        r_clr = 1'b0;
    logic        r_in_ready, r_out_valid, r_out_last, r_busy;
    logic [31:0] r_out_w, r_out_k;
    logic [5:0]  r_out_t;

    sha256_msg_sched #(.P_ROUNDS(64)) dut (
        .ACLK(aclk), .ARESET(areset), .CLR(clr),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_W(out_w), .OUT_K(out_k), .OUT_T(out_t), .OUT_LAST(out_last), .BUSY(busy)
    );

    sha256_msg_sched #(.P_ROUNDS(20)) dut_r (
        .ACLK(aclk), .ARESET(areset), .CLR(r_clr),
        .IN_VALID(r_in_valid), .IN_READY(r_in_ready), .IN_DATA(r_in_data),
        .OUT_VALID(r_out_valid), .OUT_READY(r_out_ready),
        .OUT_W(r_out_w), .OUT_K(r_out_k), .OUT_T(r_out_t), .OUT_LAST(r_out_last), .BUSY(r_busy)
    );

    always #5 aclk = ~aclk;

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] ABC_DIGEST [0:7] = '{
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] k;
        logic [5:0]  t;
        logic        last;
    } exp_t;

    int          n_chk = 0;
    int          n_err = 0;
    exp_t        q[$];
    exp_t        cmp_e;
    logic [31:0] mb [16];
    logic [31:0] mw [64];
    int          mcnt = 0;
    logic [31:0] cap_w [64];
    logic [31:0] cap_k [64];
    int          cap_n = 0;
    int          blocks_done = 0;
    logic [31:0] cur_blk [16];
    int          rdy_mode = 0;
    int          stall_left = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
    function automatic void build_sched();
        for (int t = 0; t < 16; t++) mw[t] = mb[t];
        for (int t = 16; t < 64; t++) mw[t] = ss1(mw[t-2]) + mw[t-7] + ss0(mw[t-15]) + mw[t-16];
    endfunction

    // Scoreboard: the model is "idle" when its pair queue is empty, "running" otherwise.
    always @(negedge aclk) begin
        if (areset) begin
            q.delete();
            mcnt = 0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("busy", 32'(busy), 32'(q.size() != 0));
            if (q.size() != 0) begin
                cmp_e = q[0];
                chk($sformatf("out_w t=%0d", cmp_e.t), out_w, cmp_e.w);
                chk($sformatf("out_k t=%0d", cmp_e.t), out_k, cmp_e.k);
                chk("out_t", 32'(out_t), 32'(cmp_e.t));
                chk($sformatf("out_last t=%0d", cmp_e.t), 32'(out_last), 32'(cmp_e.last));
            end else begin
                chk("out_last idle", 32'(out_last), 32'd0);
            end
            if (clr) begin
                q.delete();
                mcnt = 0;
            end else if (q.size() != 0) begin
                if (out_ready) begin
                    cap_w[cmp_e.t] = out_w;
                    cap_k[cmp_e.t] = out_k;
                    cap_n++;
                    if (cmp_e.last) blocks_done++;
                    void'(q.pop_front());
                end
            end else if (in_valid) begin
                mb[mcnt] = in_data;
                mcnt++;
                if (mcnt == 16) begin
                    build_sched();
                    for (int t = 0; t < 64; t++) q.push_back({mw[t], KT[t], 6'(t), t == 63});
                    mcnt = 0;
                    cap_n = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
            end else if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 1) == 1) begin
                out_ready = 1'b1;
            end else begin
                out_ready = 1'b0;
                stall_left = int'($urandom_range(0, 9));
            end
        end
    end

    task automatic set_abc();
        for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
        cur_blk[0] = 32'h61626380;
        cur_blk[15] = 32'h00000018;
    endtask

    task automatic send_block(input int nwords, input int gap);
        bit acc;
        int budget;
        for (int i = 0; i < nwords; i++) begin
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gap)) begin
                    @(posedge aclk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data = cur_blk[i];
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 300) begin
                @(negedge aclk);
                acc = in_ready;
                @(posedge aclk);
                #1;
                budget++;
            end
            if (!acc) chk($sformatf("in accept word %0d", i), 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (blocks_done < target && n < budget) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk($sformatf("block %0d completed", target), 32'(blocks_done >= target), 32'd1);
    endtask

    task automatic check_digest(input string nm);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        a = IV[0]; b = IV[1]; c = IV[2]; d = IV[3];
        e = IV[4]; f = IV[5]; g = IV[6]; h = IV[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + cap_k[t] + cap_w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        chk({nm, " h0"}, a + IV[0], ABC_DIGEST[0]);
        chk({nm, " h1"}, b + IV[1], ABC_DIGEST[1]);
        chk({nm, " h2"}, c + IV[2], ABC_DIGEST[2]);
        chk({nm, " h3"}, d + IV[3], ABC_DIGEST[3]);
        chk({nm, " h4"}, e + IV[4], ABC_DIGEST[4]);
        chk({nm, " h5"}, f + IV[5], ABC_DIGEST[5]);
        chk({nm, " h6"}, g + IV[6], ABC_DIGEST[6]);
        chk({nm, " h7"}, h + IV[7], ABC_DIGEST[7]);
        chk({nm, " beats"}, 32'(cap_n), 32'd64);
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, " out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, " out_t"}, 32'(out_t), 32'd0);
        chk({nm, " out_w"}, out_w, 32'd0);
        chk({nm, " out_last"}, 32'(out_last), 32'd0);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " out_k"}, out_k, 32'h428a2f98);
    endtask

    initial begin
        int beats, n;
        logic [31:0] r_exp [64];

        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        check_reset_values("reset");

        set_abc();
        for (int i = 0; i < 16; i++) mb[i] = cur_blk[i];
        build_sched();
        chk("model abc W16", mw[16], 32'h61626380);
        chk("model abc W17", mw[17], 32'h000f0000);
        for (int t = 0; t < 64; t++) r_exp[t] = mw[t];

        // golden abc, OUT_READY held high
        send_block(16, 0);
        wait_done(1, 200);
        chk("abc t0 W", cap_w[0], 32'h61626380);
        chk("abc t0 K", cap_k[0], 32'h428a2f98);
        chk("abc t15 W", cap_w[15], 32'h00000018);
        chk("abc t16 W", cap_w[16], 32'h61626380);
        chk("abc t17 W", cap_w[17], 32'h000f0000);
        chk("abc t63 K", cap_k[63], 32'hc67178f2);
        check_digest("abc digest");

        // random backpressure
        rdy_mode = 1;
        send_block(16, 0);
        wait_done(2, 3000);
        rdy_mode = 0;
        check_digest("backpressure digest");

        // gapped input
        send_block(16, 3);
        wait_done(3, 400);
        check_digest("gapped digest");

        // back-to-back: second block waits with IN_VALID high during the first block's run
        send_block(16, 0);
        cur_blk[0] = 32'h74686973;
        for (int i = 1; i < 16; i++) cur_blk[i] = 32'h01010101 * i + 32'h20000000;
        send_block(16, 0);
        wait_done(5, 300);
        chk("blk2 t0 W", cap_w[0], 32'h74686973);
        chk("blk2 beats", 32'(cap_n), 32'd64);

        // CLR during load together with an offered word, then CLR at t=20 with a handshake
        set_abc();
        send_block(5, 0);
        in_valid = 1'b1;
        in_data = 32'hdeadbeef;
        clr = 1'b1;
        @(posedge aclk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        send_block(16, 0);
        n = 0;
        while (!(out_valid && out_t == 6'd20) && n < 200) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk("reached t=20", 32'(out_valid && out_t == 6'd20), 32'd1);
        clr = 1'b1;
        @(posedge aclk);
        #1;
        clr = 1'b0;
        chk("clr out_valid", 32'(out_valid), 32'd0);
        chk("clr in_ready", 32'(in_ready), 32'd1);
        send_block(16, 0);
        wait_done(6, 200);
        check_digest("after clr digest");

        // ARESET after 7 words
        send_block(7, 0);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check_reset_values("mid reset");
        send_block(16, 0);
        wait_done(7, 200);
        check_digest("after reset digest");

        // reduced-round instance
        for (int i = 0; i < 16; i++) begin
            r_in_valid = 1'b1;
            r_in_data = cur_blk[i];
            @(posedge aclk);
            #1;
        end
        r_in_valid = 1'b0;
        beats = 0;
        n = 0;
        while (n < 60) begin
            @(negedge aclk);
            n++;
            if (r_out_valid) begin
                chk("r out_t", 32'(r_out_t), 32'(beats));
                chk($sformatf("r out_w t=%0d", beats), r_out_w, r_exp[beats]);
                chk($sformatf("r out_k t=%0d", beats), r_out_k, KT[beats]);
                chk($sformatf("r out_last t=%0d", beats), 32'(r_out_last), 32'(beats == 19));
                chk("r in_ready while run", 32'(r_in_ready), 32'd0);
                beats++;
            end else if (beats > 0) begin
                break;
            end
        end
        chk("r beats", 32'(beats), 32'd20);
        chk("r back in load", 32'(r_in_ready), 32'd1);
        chk("r busy idle", 32'(r_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

endmodule
